memory_pipe: RTL and testbench

Parametrised single-port synchronous memory, the successor of the basic 8-bit read/write memory. It adds configurable data width, depth and read latency, per-byte write enables, a ready/valid request handshake and a self-clearing init sequencer. It sits behind the memory interface as the DUT of the memory testbench, and it is the storage building block for later multi-channel designs.

---
 rtl/memory_pipe.sv | 117 +++++++++++
 tb/tb_memory_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/memory_pipe.sv
// Single-port synchronous memory with per-byte write enables, a fixed-latency read
// pipeline and a self-clearing init sequencer that zeroes the array after reset or clr_i.
module memory_pipe #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    rw_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    rdy_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    vld_o,
  output logic                    init_done_o
);

  localparam int NumBytes = int'(DATA_WIDTH / 8);
  localparam int Depth    = 2 ** ADDR_WIDTH;
  localparam int Latency  = int'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    init_done_q, init_done_d;

  logic [DATA_WIDTH-1:0]   mem [Depth];
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NumBytes-1:0]     wr_be;
  logic                    rd_acc;

  logic [Latency-1:0]      vld_pipe;
  logic [DATA_WIDTH-1:0]   data_pipe [Latency];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    wr_en       = 1'b0;
    wr_addr     = addr_i;
    wr_data     = data_i;
    wr_be       = be_i;
    rd_acc      = 1'b0;
    unique case (state_q)
      StInit: begin
        // The init sequencer shares the single write port with normal traffic.
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = '0;
        wr_be   = '1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == LastAddr) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        wr_en  = en_i && rw_i;
        rd_acc = en_i && !rw_i;
        if (clr_i) begin
          state_d = StInit;
          ptr_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (wr_be[k]) mem[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
      end
    end
  end

  // Each stage only advances data alongside a valid bit, so data_o holds between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < Latency; i++) data_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      if (rd_acc) data_pipe[0] <= mem[addr_i];
      for (int i = 1; i < Latency; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign rdy_o       = (state_q == StIdle);
  assign vld_o       = vld_pipe[Latency-1];
  assign data_o      = data_pipe[Latency-1];
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_memory_pipe.sv
// Bench for memory_pipe: directed requests push expected read data and arrival cycle into a
// queue; a negedge monitor pops and compares on every vld_o pulse and checks data_o holding.
module tb_memory_pipe;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int RL = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr_i = 1'b0;
  logic            en_i = 1'b0;
  logic            rw_i = 1'b0;
  logic [AW-1:0]   addr_i = '0;
  logic [DW/8-1:0] be_i = '0;
  logic [DW-1:0]   data_i = '0;
  logic            rdy_o;
  logic [DW-1:0]   data_o;
  logic            vld_o;
  logic            init_done_o;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] last_exp = '0;

  memory_pipe #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_i),
    .en_i       (en_i),
    .rw_i       (rw_i),
    .addr_i     (addr_i),
    .be_i       (be_i),
    .data_i     (data_i),
    .rdy_o      (rdy_o),
    .data_o     (data_o),
    .vld_o      (vld_o),
    .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (vld_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vld: got vld_o=1 data_o=%0h expected no pulse", data_o);
        end else begin
          mon_e = sb.pop_front();
          check("read_data", data_o, mon_e.data);
          check("read_cycle", cyc, mon_e.cyc);
          last_exp = mon_e.data;
        end
      end else begin
        check("data_hold", data_o, last_exp);
      end
    end
  end

  // Called just after a negedge; the request is accepted at the following posedge.
  task automatic req(input logic rw, input logic [AW-1:0] a, input logic [1:0] be,
                     input logic [DW-1:0] d, input logic clr, input logic [DW-1:0] exp);
    en_i   = 1'b1;
    rw_i   = rw;
    addr_i = a;
    be_i   = be;
    data_i = d;
    clr_i  = clr;
    check("req_rdy", rdy_o, 1);
    if (!rw) sb.push_back('{exp, cyc + RL});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en_i  = 1'b0;
    clr_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic init_wait(input logic done_kept);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("init_rdy", rdy_o, (k == 16));
      check("init_done", init_done_o, done_kept ? 1 : (k == 16));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_rdy", rdy_o, 0);
    check("rst_vld", vld_o, 0);
    check("rst_data", data_o, 0);
    check("rst_init_done", init_done_o, 0);

    // Reset release with a read held pending through INIT.
    @(negedge clk);
    en_i = 1'b1; rw_i = 1'b0; addr_i = 4'd5; rst = 1'b1;
    init_wait(1'b0);
    sb.push_back('{16'h0000, cyc + RL});
    @(negedge clk);
    idle(4);

    req(1'b1, 4'd3, 2'b11, 16'hBEEF, 1'b0, '0);
    req(1'b0, 4'd3, 2'b00, 16'h0000, 1'b0, 16'hBEEF);
    idle(5);

    req(1'b1, 4'd7, 2'b11, 16'h1234, 1'b0, '0);
    req(1'b1, 4'd7, 2'b10, 16'hABCD, 1'b0, '0);
    req(1'b0, 4'd7, 2'b00, 16'h0000, 1'b0, 16'hAB34);
    req(1'b1, 4'd7, 2'b00, 16'hFFFF, 1'b0, '0);
    req(1'b0, 4'd7, 2'b00, 16'h0000, 1'b0, 16'hAB34);
    idle(4);

    for (int i = 0; i < 16; i++) req(1'b1, AW'(i), 2'b11, DW'(i * 16'h0101), 1'b0, '0);
    for (int i = 0; i < 16; i++) req(1'b0, AW'(i), 2'b00, '0, 1'b0, DW'(i * 16'h0101));
    idle(5);

    // Clear with an in-flight read; clr_i held during INIT must not restart it.
    req(1'b1, 4'd3, 2'b11, 16'hBEEF, 1'b0, '0);
    req(1'b0, 4'd3, 2'b00, 16'h0000, 1'b1, 16'hBEEF);
    en_i = 1'b0;
    check("clr_rdy_drop", rdy_o, 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("clr_rdy", rdy_o, (k == 16));
      check("clr_init_done", init_done_o, 1);
      clr_i = (k < 10);
    end
    req(1'b0, 4'd3, 2'b00, '0, 1'b0, 16'h0000);
    req(1'b0, 4'd7, 2'b00, '0, 1'b0, 16'h0000);
    idle(4);

    req(1'b1, 4'd2, 2'b11, 16'h5A5A, 1'b0, '0);
    req(1'b0, 4'd2, 2'b00, '0, 1'b0, 16'h5A5A);
    idle(4);

    // Two reads in flight, then asynchronous reset between clock edges.
    en_i = 1'b1; rw_i = 1'b0; addr_i = 4'd2;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_vld", vld_o, 1);
    en_i = 1'b0;
    rst = 1'b0;
    last_exp = '0;
    #1;
    check("async_rst_vld", vld_o, 0);
    check("async_rst_data", data_o, 0);
    check("async_rst_rdy", rdy_o, 0);
    check("async_rst_init_done", init_done_o, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    en_i = 1'b1; rw_i = 1'b0; addr_i = 4'd2; rst = 1'b1;
    init_wait(1'b0);
    sb.push_back('{16'h0000, cyc + RL});
    @(negedge clk);
    idle(6);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
